// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and constants for the register bus arbiter
//
// Contents:
//   arb_state_t             FSM state encoding (IDLE, ISSUE, WAIT)
//   REQ_SPI/REQ_PID/REQ_SAFE requester index constants
//   ADDR_W_DEF/DATA_W_DEF   default register address / data widths
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam int REQ_SPI  = 0;
    localparam int REQ_PID  = 1;
    localparam int REQ_SAFE = 2;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/reg_arb_pick.sv
// rtl/reg_arb_pick.sv - combinational winner selection for the register bus arbiter
//
// Ports:
//   req     in  [2:0]  per-requester request (0=SPI, 1=PID, 2=safety)
//   rr_ptr  in  1      round-robin preference between 0 and 1 (0 favours SPI)
//   gnt     out [2:0]  one-hot winner, all zero when no request
//   idx     out [1:0]  index of the winner (0 when no request)
//   valid   out 1      at least one request present
module reg_arb_pick
    import reg_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       rr_ptr,
    output logic [2:0] gnt,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        gnt   = '0;
        idx   = 2'(REQ_SPI);
        valid = |req;
        if (req[REQ_SAFE]) begin
            // Safety/allstop always wins regardless of the round-robin state.
            gnt[REQ_SAFE] = 1'b1;
            idx           = 2'(REQ_SAFE);
        end else if (req[REQ_SPI] && req[REQ_PID]) begin
            if (rr_ptr) begin
                gnt[REQ_PID] = 1'b1;
                idx          = 2'(REQ_PID);
            end else begin
                gnt[REQ_SPI] = 1'b1;
                idx          = 2'(REQ_SPI);
            end
        end else if (req[REQ_SPI]) begin
            gnt[REQ_SPI] = 1'b1;
            idx          = 2'(REQ_SPI);
        end else if (req[REQ_PID]) begin
            gnt[REQ_PID] = 1'b1;
            idx          = 2'(REQ_PID);
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - three-requester arbiter in front of a single register port
//
// Optional feature: define REG_ARB_TIMEOUT_EN to abort a WAIT that sees no
// bus_ack within TIMEOUT_CYCLES cycles (done+err to the owner, rdata=0).
//
// Ports:
//   SYS_CLK    in   1               clock
//   RESET      in   1               asynchronous active-high reset
//   req/we     in   [2:0]           per-requester request / write enable
//   addr       in   [3*ADDR_W-1:0]  per-requester address, slice i = requester i
//   wdata      in   [3*DATA_W-1:0]  per-requester write data
//   gnt        out  [2:0]           one-hot owner for the whole transaction
//   done/err   out  [2:0]           one-cycle completion / abort pulse to the owner
//   rdata      out  [DATA_W-1:0]    read data, valid in the done cycle
//   bus_req    out  1               one-cycle downstream strobe
//   bus_we     out  1               downstream direction
//   bus_addr   out  [ADDR_W-1:0]    latched address
//   bus_wdata  out  [DATA_W-1:0]    latched write data
//   bus_ack    in   1               downstream completion (only looked at in WAIT)
//   bus_rdata  in   [DATA_W-1:0]    downstream read data
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                SYS_CLK,
    input  logic                RESET,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          done,
    output logic [2:0]          err,
    output logic [DATA_W-1:0]   rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);

    arb_state_t          state_q, state_nxt;
    logic [2:0]          gnt_q, gnt_nxt;
    logic [2:0]          done_q, done_nxt;
    logic                bus_req_q, bus_req_nxt;
    logic                bus_we_q, bus_we_nxt;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_nxt;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_nxt;
    logic [DATA_W-1:0]   rdata_q, rdata_nxt;
    logic                rr_q, rr_nxt;

    logic [2:0]          pick_gnt;
    logic [1:0]          pick_idx;
    logic                pick_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [2:0]          err_q, err_nxt;
`else
    // The timeout length only matters when the timeout option is built in.
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    reg_arb_pick u_pick (
        .req   (req),
        .rr_ptr(rr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        case (pick_idx)
            2'd1:    begin
                sel_addr  = addr[ADDR_W +: ADDR_W];
                sel_wdata = wdata[DATA_W +: DATA_W];
            end
            2'd2:    begin
                sel_addr  = addr[2*ADDR_W +: ADDR_W];
                sel_wdata = wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                sel_addr  = addr[0 +: ADDR_W];
                sel_wdata = wdata[0 +: DATA_W];
            end
        endcase
    end

    always_comb begin
        state_nxt     = state_q;
        gnt_nxt       = gnt_q;
        done_nxt      = '0;
        bus_req_nxt   = 1'b0;
        bus_we_nxt    = bus_we_q;
        bus_addr_nxt  = bus_addr_q;
        bus_wdata_nxt = bus_wdata_q;
        rdata_nxt     = rdata_q;
        rr_nxt        = rr_q;
`ifdef REG_ARB_TIMEOUT_EN
        err_nxt       = '0;
        cnt_nxt       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_nxt = '0;
                if (pick_valid) begin
                    gnt_nxt       = pick_gnt;
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = |(we & pick_gnt);
                    bus_addr_nxt  = sel_addr;
                    bus_wdata_nxt = sel_wdata;
                    // A 0/1 grant hands preference to the other one; safety grants leave it alone.
                    if (!pick_gnt[REQ_SAFE]) begin
                        rr_nxt = pick_gnt[REQ_SPI];
                    end
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        rdata_nxt = bus_rdata;
                    end
                    done_nxt  = gnt_q;
                    gnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done_nxt  = gnt_q;
                    err_nxt   = gnt_q;
                    rdata_nxt = '0;
                    gnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            rr_q        <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
            err_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            gnt_q       <= gnt_nxt;
            done_q      <= done_nxt;
            bus_req_q   <= bus_req_nxt;
            bus_we_q    <= bus_we_nxt;
            bus_addr_q  <= bus_addr_nxt;
            bus_wdata_q <= bus_wdata_nxt;
            rdata_q     <= rdata_nxt;
            rr_q        <= rr_nxt;
`ifdef REG_ARB_TIMEOUT_EN
            err_q       <= err_nxt;
            cnt_q       <= cnt_nxt;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;
`ifdef REG_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = '0;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - scoreboard bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic            SYS_CLK = 1'b0;
    logic            RESET;
    logic [2:0]      req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, done, err;
    logic [DW-1:0]   rdata;
    logic            bus_req, bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_ack;
    logic [DW-1:0]   bus_rdata;

    typedef struct {
        logic [2:0]    gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] ack_rdata;
        logic [DW-1:0] exp_rdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_rdata;
    int            n_tests = 0;
    int            n_fail  = 0;

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .SYS_CLK  (SYS_CLK),
        .RESET    (RESET),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Expected order of grants is decided by the caller; rdata follows reads in push order.
    task automatic push_exp(input int who, input logic [DW-1:0] ack_rd);
        exp_t e;
        e.gnt       = 3'b001 << who;
        e.we        = we[who];
        e.addr      = addr[who*AW +: AW];
        e.wdata     = wdata[who*DW +: DW];
        e.ack_rdata = ack_rd;
        if (!we[who]) model_rdata = ack_rd;
        e.exp_rdata = model_rdata;
        exp_q.push_back(e);
    endtask

    task automatic check_issue(input exp_t e);
        chk("gnt_issue", 32'(gnt), 32'(e.gnt));
        chk("bus_req_issue", 32'(bus_req), 32'd1);
        chk("bus_we", 32'(bus_we), 32'(e.we));
        chk("bus_addr", 32'(bus_addr), 32'(e.addr));
        chk("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
    endtask

    // Called at the negedge of the cycle in which the grant decision is sampled.
    task automatic service(input int ack_delay, input logic [2:0] drop_mask, input logic [2:0] raise_mask);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        @(negedge SYS_CLK);
        check_issue(e);
        @(negedge SYS_CLK);
        chk("bus_req_one_cycle", 32'(bus_req), 32'd0);
        chk("gnt_held", 32'(gnt), 32'(e.gnt));
        req = (req & ~drop_mask) | raise_mask;
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge SYS_CLK);
            chk("done_before_ack", 32'(done), 32'd0);
            chk("gnt_in_wait", 32'(gnt), 32'(e.gnt));
        end
        bus_ack   = 1'b1;
        bus_rdata = e.ack_rdata;
        @(negedge SYS_CLK);
        bus_ack   = 1'b0;
        bus_rdata = 16'hFFFF;
        chk("done", 32'(done), 32'(e.gnt));
        chk("err", 32'(err), 32'd0);
        chk("rdata", 32'(rdata), 32'(e.exp_rdata));
        chk("gnt_clear", 32'(gnt), 32'd0);
    endtask

    initial begin
        exp_t e;
        bit   saw_done;
        RESET       = 1'b1;
        req         = '0;
        we          = '0;
        addr        = '0;
        wdata       = '0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        model_rdata = '0;

        // Reset state
        @(negedge SYS_CLK);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        RESET = 1'b0;
        @(negedge SYS_CLK);

        // Single SPI write; req dropped mid-transaction, write ignores bus_rdata
        req = 3'b001; we = 3'b001;
        addr[0*AW +: AW]  = 10'd29;
        wdata[0*DW +: DW] = 16'h00A5;
        push_exp(0, 16'hBEEF);
        service(0, 3'b001, 3'b000);

        // PID read of addr 20
        req = 3'b010; we = 3'b000;
        addr[1*AW +: AW]  = 10'd20;
        wdata[1*DW +: DW] = 16'h7777;
        push_exp(1, 16'h1234);
        service(2, 3'b000, 3'b000);
        req = 3'b000;

        // Round-robin between SPI and PID, req held: 0,1,0,1
        req = 3'b011; we = 3'b011;
        addr[0*AW +: AW]  = 10'd1;   wdata[0*DW +: DW] = 16'h1111;
        addr[1*AW +: AW]  = 10'd2;   wdata[1*DW +: DW] = 16'h2222;
        push_exp(0, 16'h0BAD);
        push_exp(1, 16'h0BAD);
        push_exp(0, 16'h0BAD);
        push_exp(1, 16'h0BAD);
        service(0, 3'b000, 3'b000);
        service(1, 3'b000, 3'b000);
        service(3, 3'b000, 3'b000);
        service(0, 3'b000, 3'b000);
        req = 3'b000;

        // Safety first, then 0, then 1; req[2] raised during 1's transaction goes next
        req = 3'b111; we = 3'b101;
        addr[2*AW +: AW]  = 10'd900; wdata[2*DW +: DW] = 16'hCAFE;
        push_exp(2, 16'h0000);
        push_exp(0, 16'h0000);
        push_exp(1, 16'h5A5A);
        push_exp(2, 16'h0000);
        service(0, 3'b000, 3'b000);
        req[2] = 1'b0;
        service(1, 3'b000, 3'b000);
        req[0] = 1'b0;
        service(1, 3'b000, 3'b100);
        req[1] = 1'b0;
        service(0, 3'b000, 3'b000);
        req[2] = 1'b0;

        // bus_ack with nothing in flight is ignored
        bus_ack = 1'b1;
        @(negedge SYS_CLK);
        bus_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_gnt", 32'(gnt), 32'd0);
        @(negedge SYS_CLK);
        chk("idle_ack_bus_req", 32'(bus_req), 32'd0);

        // Downstream never acknowledges
        req = 3'b001; we = 3'b000;
        addr[0*AW +: AW] = 10'd7;
        saw_done = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
        model_rdata = '0;
        push_exp(0, 16'h0000);
        e = exp_q.pop_front();
        @(negedge SYS_CLK);
        check_issue(e);
        for (int i = 0; i < 8; i++) begin
            @(negedge SYS_CLK);
            req = 3'b000;
            if (done != 3'b000) saw_done = 1'b1;
        end
        chk("timeout_early_done", 32'(saw_done), 32'd0);
        @(negedge SYS_CLK);
        chk("timeout_done", 32'(done), 32'b001);
        chk("timeout_err", 32'(err), 32'b001);
        chk("timeout_rdata", 32'(rdata), 32'd0);
        chk("timeout_gnt", 32'(gnt), 32'd0);
        // new transaction to interrupt with reset
        req = 3'b001;
        push_exp(0, 16'h0000);
        e = exp_q.pop_front();
        @(negedge SYS_CLK);
        check_issue(e);
        @(negedge SYS_CLK);
`else
        push_exp(0, 16'h0000);
        e = exp_q.pop_front();
        @(negedge SYS_CLK);
        check_issue(e);
        for (int i = 0; i < 1000; i++) begin
            @(negedge SYS_CLK);
            if (done != 3'b000 || err != 3'b000) saw_done = 1'b1;
        end
        chk("no_timeout_done", 32'(saw_done), 32'd0);
        chk("no_timeout_gnt", 32'(gnt), 32'b001);
`endif

        // Reset in WAIT: outputs drop at once, no done; pointer back to 0
        #2 RESET = 1'b1;
        #1;
        chk("rst_wait_gnt", 32'(gnt), 32'd0);
        chk("rst_wait_bus_req", 32'(bus_req), 32'd0);
        chk("rst_wait_done", 32'(done), 32'd0);
        chk("rst_wait_err", 32'(err), 32'd0);
        @(negedge SYS_CLK);
        RESET = 1'b0;
        exp_q.delete();
        model_rdata = '0;
        chk("rst_release_done", 32'(done), 32'd0);
        chk("rst_release_rdata", 32'(rdata), 32'd0);
        req = 3'b011; we = 3'b000;
        push_exp(0, 16'h4321);
        service(0, 3'b000, 3'b000);
        req = 3'b000;
        @(negedge SYS_CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
